// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures adder result with Z/N/V flags behind a
// two-entry skid buffer. Define ALU_RESULT_STAGE_COUNT_EN for the output-handshake counter.
module alu_result_stage #(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_LENGTH-1:0] adder_result,
  input  logic                      opd1_msb,
  input  logic                      opd2_msb,
  input  logic [3:0]                alu_op_select,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_LENGTH-1:0] result_q,
  output logic                      flag_z,
  output logic                      flag_n,
  output logic                      flag_v,
  output logic [15:0]               result_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPERAND_LENGTH-1:0] result;
    logic                      z;
    logic                      n;
    logic                      v;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   in_ready_q;
  logic   accept, pop;
  logic   load_main_in, load_main_skid, load_skid;
  logic   res_msb;

  // Only bit 3 distinguishes add from subtract; the low bits are don't-care here.
  logic   unused_op_bits;
  assign unused_op_bits = ^alu_op_select[2:0];

  assign res_msb = adder_result[OPERAND_LENGTH-1];

  always_comb begin
    in_entry.result = adder_result;
    in_entry.z      = (adder_result == '0);
    in_entry.n      = res_msb;
    // Subtract feeds the inverted operand 2, so its same-sign test flips.
    if (alu_op_select[3]) in_entry.v = (opd1_msb != opd2_msb) && (res_msb != opd1_msb);
    else                  in_entry.v = (opd1_msb == opd2_msb) && (res_msb != opd1_msb);
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // NOTE: the data entries are reset too, because the outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  assign result_q = main_q.result;
  assign flag_z   = main_q.z;
  assign flag_n   = main_q.n;
  assign flag_v   = main_q.v;

`ifdef ALU_RESULT_STAGE_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_q <= '0;
    else if (pop) count_q <= count_q + 16'd1;
  end

  assign result_count = count_q;
`else
  assign result_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model checked every
// cycle, plus directed literal cases for flags, backpressure, reset and the counter.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] adder_result;
  logic        opd1_msb, opd2_msb;
  logic [3:0]  alu_op_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_q;
  logic        flag_z, flag_n, flag_v;
  logic [15:0] result_count;

  alu_result_stage #(.OPERAND_LENGTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .adder_result (adder_result),
    .opd1_msb     (opd1_msb),
    .opd2_msb     (opd2_msb),
    .alu_op_select(alu_op_select),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_q     (result_q),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Operands as the adder saw them; the model recomputes everything from these.
  logic [31:0] tb_a, tb_b;
  bit          tb_sub;

  typedef struct {
    logic [31:0] r;
    bit          z, n, v;
  } exp_t;

  exp_t        q[$];
  bit          m_ready = 1'b1;
  logic [15:0] m_count = '0;
  bit          m_pop, m_acc;

  // Overflow means the exact signed sum does not survive truncation to 32 bits.
  function automatic exp_t make_exp(logic [31:0] a, logic [31:0] b, bit sub);
    exp_t   e;
    longint s;
    s   = sub ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b));
    e.r = s[31:0];
    e.z = (e.r == 32'd0);
    e.n = (s[31:0] > 32'h7FFF_FFFF);
    e.v = (s != longint'($signed(e.r)));
    return e;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_ready = 1'b1;
      m_count = '0;
    end else begin
      m_pop = (q.size() > 0) && out_ready;
      m_acc = in_valid && m_ready;
      if (m_pop) begin
        void'(q.pop_front());
`ifdef ALU_RESULT_STAGE_COUNT_EN
        m_count = m_count + 16'd1;
`endif
      end
      if (m_acc) q.push_back(make_exp(tb_a, tb_b, tb_sub));
      m_ready = (q.size() < 2);
    end
  end

  // Continuous comparison against the model, one step after every rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, m_ready);
      check("result_count", result_count, m_count);
      if (q.size() > 0) begin
        check("result_q", result_q, q[0].r);
        check("flag_z", flag_z, q[0].z);
        check("flag_n", flag_n, q[0].n);
        check("flag_v", flag_v, q[0].v);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, input logic [2:0] junk);
    in_valid      = v;
    tb_a          = a;
    tb_b          = b;
    tb_sub        = sub;
    adder_result  = sub ? a - b : a + b;
    opd1_msb      = a[31];
    opd2_msb      = b[31];
    alu_op_select = {sub, junk};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_result_q"}, result_q, 32'd0);
    check({tag, "_flags"}, {flag_z, flag_n, flag_v}, 3'b000);
    check({tag, "_count"}, result_count, 16'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Overflow add: 0x40000000 + 0x40000000.
    out_ready = 1'b1;
    drive(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 3'd0);
    tick();
    check("ovf_add_valid", out_valid, 1'b1);
    check("ovf_add_result", result_q, 32'h8000_0000);
    check("ovf_add_znv", {flag_z, flag_n, flag_v}, 3'b011);
    // Zero subtract: 5 - 5.
    drive(1'b1, 32'd5, 32'd5, 1'b1, 3'd0);
    tick();
    check("zero_sub_result", result_q, 32'h0);
    check("zero_sub_znv", {flag_z, flag_n, flag_v}, 3'b100);
    // Subtract overflow: 0x80000000 - 1.
    drive(1'b1, 32'h8000_0000, 32'd1, 1'b1, 3'd5);
    tick();
    check("sub_ovf_result", result_q, 32'h7FFF_FFFF);
    check("sub_ovf_znv", {flag_z, flag_n, flag_v}, 3'b001);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    tick();
    check("drained", out_valid, 1'b0);

    // Backpressure: two entries fill the stage, the third is held off.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'd0, 1'b0, 3'd0);
    tick();
    check("bp_ready_after_one", in_ready, 1'b1);
    drive(1'b1, 32'h22, 32'd0, 1'b0, 3'd0);
    tick();
    drive(1'b1, 32'h33, 32'd0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_head", result_q, 32'h11);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_second", result_q, 32'h22);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    check("bp_third", result_q, 32'h33);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Streaming: 100 back-to-back items with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'(i + 1), 32'd0, 1'b0, 3'd0);
      tick();
      check("stream_valid", out_valid, 1'b1);
      check("stream_data", result_q, 32'(i + 1));
      check("stream_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    tick();
    check("stream_drained", out_valid, 1'b0);

    // Random traffic with random backpressure; the model checks every cycle.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(9, 0) < 7, $urandom, $urandom, 1'($urandom), 3'($urandom));
      out_ready = ($urandom_range(9, 0) < 6);
      tick();
    end

    // Reset between edges while FULL.
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'd0, 1'b0, 3'd0);
    tick();
    tick();
    tick();
    check("pre_reset_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    drive(1'b1, 32'h5, 32'd0, 1'b0, 3'd0);
    out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", out_valid, 1'b1);
    check("post_reset_data", result_q, 32'h5);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    tick();
    check("post_reset_alone", out_valid, 1'b0);

    // Counter wrap: exactly 65537 output handshakes after a fresh reset.
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 32'(i), 32'd3, 1'b0, 3'd0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    tick();
    tick();
    check("wrap_drained", out_valid, 1'b0);
`ifdef ALU_RESULT_STAGE_COUNT_EN
    check("count_wrapped", result_count, 16'd1);
`else
    check("count_tied_zero", result_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
